// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, default width and counter-width helper for the shift-add multiplier
package mul_pkg;
  localparam int MUL_DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/mul_abs_neg.sv
// mul_abs_neg: conditional two's-complement negation, used for operand magnitudes and the final sign fix
module mul_abs_neg #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic [WIDTH-1:0] result
);
  assign result = en ? -value : value;
endmodule

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: radix-2 sequential shift-add multiplier with signed/unsigned mode and start/done handshake
module seq_shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0] acc, sum;
  logic [WIDTH-1:0] ma, mb, abs_a, abs_b;
  logic [2*WIDTH-1:0] fixed;
  logic neg, accept;
  mul_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
    .value(multiplicand), .en(signed_mode & multiplicand[WIDTH-1]), .result(abs_a)
  );
  mul_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .value(multiplier), .en(signed_mode & multiplier[WIDTH-1]), .result(abs_b)
  );
  mul_abs_neg #(.WIDTH(2*WIDTH)) u_fix (
    .value({acc[WIDTH-1:0], mb}), .en(neg), .result(fixed)
  );
  assign sum = acc + (mb[0] ? {1'b0, ma} : '0);
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Next state and handshake outputs; a start in the done cycle is accepted since that cycle is IDLE
  always_comb begin
    ready = state == IDLE;
    busy = !ready;
    accept = ready & start;
    state_n = accept ? CALC :
              (state == CALC) ? ((count == LAST) ? FIX : CALC) :
              IDLE;
  end
  // Datapath: operand load, one add-and-shift per CALC cycle, sign fix and done pulse on FIX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      acc <= '0;
      ma <= '0;
      mb <= '0;
      neg <= 1'b0;
      done <= 1'b0;
      product <= '0;
    end else begin
      done <= state == FIX;
      if (accept) begin
        ma <= abs_a;
        mb <= abs_b;
        neg <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        acc <= '0;
        count <= '0;
      end else if (state == CALC) begin
        acc <= {1'b0, sum[WIDTH:1]};
        mb <= {sum[0], mb[WIDTH-1:1]};
        count <= count + 1'b1;
      end
      if (state == FIX) product <= fixed;
    end
endmodule

// File: doc/seq_shift_add_mul.md
Name: seq_shift_add_mul

Overview:
- Parametrised sequential radix-2 shift-add multiplier. Next generation of the lab's serial multiplier, with WIDTH-generic operands and signed/unsigned mode.
- Adds a start/ready/done handshake, a full-width parallel product and asynchronous reset.
- Consumes one multiplier bit per cycle.
- Sits between the operand register file and the result bus. Suitable wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration-counter width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only on an edge where ready=1.
- signed_mode  in  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- multiplicand  in  WIDTH  operand A; sampled on the accepting edge.
- multiplier  in  WIDTH  operand B; sampled on the accepting edge.
- ready  out  1  high in IDLE; also high during the done cycle.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; product valid.
- product  out  2*WIDTH  result; held until the next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, internal accumulator=0, product=0, done=0, busy=0, ready=1. Reset mid-operation aborts the operation silently; no done is produced.
- States: IDLE, CALC, FIX. A start accepted during the done cycle overlaps that cycle (back-to-back operation).
- IDLE:
  - On the edge with start=1, load the magnitudes of the operands.
  - Unsigned mode: magnitudes are the operands unchanged.
  - Signed mode: the magnitude of each negative operand is its two's complement.
  - Latch neg = signed_mode & (A[MSB] ^ B[MSB]).
  - Clear accumulator, count=0, go to CALC.
- CALC: one iteration per cycle on the {acc[WIDTH:0], mb[WIDTH-1:0]} register.
  - If mb[0]=1, acc += {1'b0, ma}.
  - Then shift the whole register right by 1.
  - count increments each iteration. After WIDTH iterations (count==WIDTH-1 on that edge) go to FIX.
- FIX: on one edge, product <= neg ? -P : P, where P is the low 2*WIDTH bits. Pulse done=1 for the following cycle; return to IDLE.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+WIDTH+1, i.e. WIDTH+2 edges from acceptance.
- Throughput: one result per WIDTH+2 cycles.
- Handshake rules:
  - start while busy=1 is ignored (no queueing, no restart).
  - Operand and mode inputs are don't-care except on the accepting edge; changing them mid-operation has no effect.
  - start=1 held continuously gives back-to-back operations with no gap.
- Arithmetic and width rules:
  - The full product is always exact; there is no truncation and no overflow flag.
  - Signed most-negative case: -2^(WIDTH-1) magnitude is 2^(WIDTH-1), which fits in WIDTH unsigned bits. (-2^(W-1))^2 = 2^(2W-2) fits in 2*WIDTH signed bits.
  - A zero operand still takes the full WIDTH+2 cycles (no early termination).
  - In signed mode a zero result with neg=1 negates to 0.
- product only changes on the FIX edge and on reset. done never asserts without a preceding accepted start.

Decomposition:
- Package mul_pkg:
  - state typedef enum {IDLE, CALC, FIX} (2-bit).
  - localparam function for CNT_W.
  - Shared constant MUL_DEFAULT_WIDTH=8.
- One natural sub-module: mul_abs_neg. It is a combinational WIDTH-parametric conditional two's-complement unit (in: value, en; out: en ? -value : value), instantiated for each operand at load. A 2*WIDTH instance performs the sign fix in FIX.
- FSM, counter and datapath registers stay in the top module.

Test Plan:
- WIDTH=8, unsigned: 13 x 11 -> done in the cycle after edge 9 from acceptance; product=16'h008F; ready low in between; busy high for exactly 9 cycles.
- WIDTH=8, unsigned extreme: 255 x 255 -> product=16'hFE01. Then 0 x 200 -> product=16'h0000 with the same 10-edge latency.
- WIDTH=8, signed: -3 x 5 -> 16'hFFF1; -128 x -128 -> 16'h4000; 127 x -128 -> 16'hC080; -1 x -1 -> 16'h0001.
- Handshake:
  - start pulsed again 3 cycles into an operation with different operands -> ignored; first result correct; exactly one done.
  - start held high -> consecutive done pulses exactly 10 cycles apart.
  - Operands toggled every cycle during CALC -> result unaffected.
- Reset mid-op: rst_n low for 1 cycle (asynchronous, between edges) at iteration 4 -> outputs immediately 0 / ready=1; no done afterwards; a new start of 6 x 7 gives 16'h002A.
- Parameter sweep: WIDTH=4 and WIDTH=16 with 1000 random signed and unsigned pairs against a reference model. Latency must be WIDTH+2; product bit-exact.
